can_crc_ctrl: RTL and testbench

- Sequences the receive-side CRC engine (CRC-15/17/21 shift registers) for Classical CAN and CAN FD frames.
- Initializes the engine at SOF and gates its enable bit by bit up to the CRC field.
- Selects the CRC width from FDF/DLC, checks the FD stuff-count field, captures the received CRC sequence and compares it against the frozen engine result.
- Sits between the bit-stream processor / destuffer and can_crc.

---
 rtl/can_crc_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_can_crc_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/can_crc_ctrl.sv
// Receive-side CRC sequencer for Classical CAN / CAN FD: drives the CRC engine,
// checks the FD stuff-count field and compares the received CRC sequence.
module can_crc_ctrl #(
    parameter int Tp = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_point,
    input  logic        rx_bit,
    input  logic        rx_stuff,
    input  logic        sof,
    input  logic        crc_field_start,
    input  logic        fdf,
    input  logic [3:0]  dlc,
    input  logic        abort,
    input  logic [14:0] crc_15_i,
    input  logic [16:0] crc_17_i,
    input  logic [20:0] crc_21_i,
    output logic        crc_initialize,
    output logic        crc_enable,
    output logic        crc_data,
    output logic        crc_stuff_bit,
    output logic [1:0]  crc_sel,
    output logic        busy,
    output logic        crc_check_done,
    output logic        crc_err,
    output logic        stuff_cnt_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
        SCNT  = 3'd2,
        RXCRC = 3'd3,
        CHECK = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_stuff_cnt;
    logic [4:0]  r_bit_cnt;
    logic [19:0] r_rx_crc;
    logic [1:0]  r_crc_sel;
    logic        r_scnt_mis;
    logic        r_check_done;
    logic        r_crc_err;
    logic        r_stuff_cnt_err;

    logic        w_sof_sp;
    logic        w_cfs_calc;
    logic [1:0]  w_sel_new;
    logic [1:0]  w_sel_eff;
    logic [4:0]  w_last_idx;
    logic        w_in_field;
    state_t      w_fstate;
    logic [4:0]  w_cnt_base;
    logic        w_mis_base;
    logic [20:0] w_rx_crc_shift;
    logic        w_take;
    logic [2:0]  w_gray;
    logic [3:0]  w_scnt_vec;
    logic        w_scnt_exp;
    logic        w_scnt_bad;
    logic        w_crc_mis;

    // The crc_field_start sample is handled as the first field bit of the
    // state being entered, so the CALC case uses freshly cleared bases.
    always_comb begin
        w_sof_sp   = sof & sample_point;
        w_cfs_calc = sample_point & crc_field_start & (r_state == CALC);

        w_sel_new = 2'd0;
        if (fdf) begin
            w_sel_new = (dlc <= 4'd10) ? 2'd1 : 2'd2;
        end
        w_sel_eff = (r_state == CALC) ? w_sel_new : r_crc_sel;

        case (w_sel_eff)
            2'd0:    w_last_idx = 5'd14;
            2'd1:    w_last_idx = 5'd16;
            default: w_last_idx = 5'd20;
        endcase

        w_in_field = (r_state == SCNT) || (r_state == RXCRC) ||
                     ((r_state == CALC) && crc_field_start);
        w_fstate   = r_state;
        w_cnt_base = r_bit_cnt;
        w_mis_base = r_scnt_mis;
        w_rx_crc_shift = {r_rx_crc, rx_bit};
        if (r_state == CALC) begin
            w_fstate       = fdf ? SCNT : RXCRC;
            w_cnt_base     = 5'd0;
            w_mis_base     = 1'b0;
            w_rx_crc_shift = {20'd0, rx_bit};
        end

        w_take = sample_point & w_in_field & ~rx_stuff & ~sof & ~abort;

        w_gray     = {r_stuff_cnt[2], r_stuff_cnt[2] ^ r_stuff_cnt[1],
                      r_stuff_cnt[1] ^ r_stuff_cnt[0]};
        w_scnt_vec = {w_gray, ^w_gray};
        w_scnt_exp = w_scnt_vec[2'd3 - w_cnt_base[1:0]];
        w_scnt_bad = w_mis_base | (rx_bit != w_scnt_exp);

        case (w_sel_eff)
            2'd0:    w_crc_mis = (w_rx_crc_shift[14:0] != crc_15_i);
            2'd1:    w_crc_mis = (w_rx_crc_shift[16:0] != crc_17_i);
            default: w_crc_mis = (w_rx_crc_shift[20:0] != crc_21_i);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = IDLE;
        end else if (w_sof_sp) begin
            w_state_nxt = CALC;
        end else begin
            case (r_state)
                IDLE:  w_state_nxt = IDLE;
                CALC:  if (w_cfs_calc) w_state_nxt = w_fstate;
                SCNT:  if (w_take && (w_cnt_base == 5'd3)) w_state_nxt = RXCRC;
                RXCRC: if (w_take && (w_cnt_base == w_last_idx)) w_state_nxt = CHECK;
                CHECK: w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= IDLE;
            r_stuff_cnt     <= 3'd0;
            r_bit_cnt       <= 5'd0;
            r_rx_crc        <= 20'd0;
            r_crc_sel       <= 2'd0;
            r_scnt_mis      <= 1'b0;
            r_check_done    <= 1'b0;
            r_crc_err       <= 1'b0;
            r_stuff_cnt_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_check_done <= 1'b0;
            if (abort) begin
                r_bit_cnt       <= 5'd0;
                r_crc_err       <= 1'b0;
                r_stuff_cnt_err <= 1'b0;
            end else if (w_sof_sp) begin
                r_stuff_cnt     <= 3'd0;
                r_bit_cnt       <= 5'd0;
                r_crc_err       <= 1'b0;
                r_stuff_cnt_err <= 1'b0;
            end else if (sample_point) begin
                if ((r_state == CALC) && !crc_field_start && rx_stuff) begin
                    r_stuff_cnt <= r_stuff_cnt + 3'd1;
                end
                if (w_cfs_calc) begin
                    r_crc_sel  <= w_sel_new;
                    r_bit_cnt  <= 5'd0;
                    r_rx_crc   <= 20'd0;
                    r_scnt_mis <= 1'b0;
                end
                if (w_take) begin
                    if (w_fstate == SCNT) begin
                        if (w_cnt_base == 5'd3) begin
                            r_stuff_cnt_err <= w_scnt_bad;
                            r_bit_cnt       <= 5'd0;
                            r_scnt_mis      <= 1'b0;
                        end else begin
                            r_scnt_mis <= w_scnt_bad;
                            r_bit_cnt  <= w_cnt_base + 5'd1;
                        end
                    end else begin
                        r_rx_crc  <= w_rx_crc_shift[19:0];
                        r_bit_cnt <= w_cnt_base + 5'd1;
                        if (w_cnt_base == w_last_idx) begin
                            r_crc_err    <= w_crc_mis;
                            r_check_done <= 1'b1;
                            r_bit_cnt    <= 5'd0;
                        end
                    end
                end
            end
        end
    end

    // SOF is dominant, so it is never shifted even when it restarts a busy frame.
    assign crc_initialize = w_sof_sp;
    assign crc_enable     = sample_point & ~sof &
                            (((r_state == CALC) & ~crc_field_start) |
                             ((r_state == SCNT) & ~rx_stuff));
    assign crc_data       = rx_bit;
    assign crc_stuff_bit  = rx_stuff;
    assign crc_sel        = r_crc_sel;
    assign busy           = (r_state != IDLE);
    assign crc_check_done = r_check_done;
    assign crc_err        = r_crc_err;
    assign stuff_cnt_err  = r_stuff_cnt_err;

endmodule

// File: tb/tb_can_crc_ctrl.sv
// Directed bench for can_crc_ctrl: frames are driven bit by bit, expected check
// results are queued and compared by a monitor on each crc_check_done pulse.
module tb_can_crc_ctrl;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        rst = 1'b0;
    logic        sample_point = 1'b0;
    logic        rx_bit = 1'b1;
    logic        rx_stuff = 1'b0;
    logic        sof = 1'b0;
    logic        crc_field_start = 1'b0;
    logic        fdf = 1'b0;
    logic [3:0]  dlc = 4'd0;
    logic        abort = 1'b0;
    logic [14:0] crc_15_i = 15'h4599;
    logic [16:0] crc_17_i = 17'h1ABCD;
    logic [20:0] crc_21_i = 21'h15A5A5;
    logic        crc_initialize, crc_enable, crc_data, crc_stuff_bit;
    logic [1:0]  crc_sel;
    logic        busy, crc_check_done, crc_err, stuff_cnt_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q[$];   // {crc_err, stuff_cnt_err, crc_sel}

    can_crc_ctrl #(.Tp(1)) dut (
        .clk(clk), .rst(rst), .sample_point(sample_point), .rx_bit(rx_bit),
        .rx_stuff(rx_stuff), .sof(sof), .crc_field_start(crc_field_start),
        .fdf(fdf), .dlc(dlc), .abort(abort), .crc_15_i(crc_15_i),
        .crc_17_i(crc_17_i), .crc_21_i(crc_21_i),
        .crc_initialize(crc_initialize), .crc_enable(crc_enable),
        .crc_data(crc_data), .crc_stuff_bit(crc_stuff_bit), .crc_sel(crc_sel),
        .busy(busy), .crc_check_done(crc_check_done), .crc_err(crc_err),
        .stuff_cnt_err(stuff_cnt_err)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && crc_check_done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1 expected no check at %0t", $time);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                check("sb_crc_err", crc_err, e[3]);
                check("sb_stuff_cnt_err", stuff_cnt_err, e[2]);
                check("sb_crc_sel", crc_sel, e[1:0]);
            end
        end
    end

    task automatic send_bit(input logic b, input logic st, input logic sf,
                            input logic cfs, input logic ab, input int exp_en);
        rx_bit = b; rx_stuff = st; sof = sf; crc_field_start = cfs; abort = ab;
        sample_point = 1'b1;
        #1;
        check("crc_initialize", crc_initialize, sf);
        if (exp_en >= 0) check("crc_enable", crc_enable, exp_en[0]);
        @(posedge clk); #1;
        sample_point = 1'b0; sof = 1'b0; crc_field_start = 1'b0;
        abort = 1'b0; rx_stuff = 1'b0;
    endtask

    task automatic gap();
        sample_point = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic frame(input logic fd, input logic [3:0] d, input int nstuff,
                         input logic [3:0] scnt, input logic [20:0] rxv, input int len,
                         input logic [3:0] expv, input int abort_at);
        logic b;
        fdf = fd; dlc = d;
        send_bit(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1); gap();
        send_bit(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);  gap();
        for (int i = 0; i < nstuff; i++) begin
            send_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1); gap();
        end
        if (abort_at < 0) exp_q.push_back(expv);
        if (fd) begin
            send_bit(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0); gap();
            for (int i = 0; i < 4; i++) begin
                send_bit(scnt[3-i], 1'b0, 1'b0, 1'b0, 1'b0, 1); gap();
            end
            send_bit(~scnt[0], 1'b1, 1'b0, 1'b0, 1'b0, 0); gap();
        end
        for (int i = 0; i < len; i++) begin
            b = rxv[len-1-i];
            if (i == len - 1 && abort_at < 0) check("done_early", crc_check_done, 1'b0);
            send_bit(b, 1'b0, 1'b0, (!fd && i == 0), (i == abort_at), 0);
            if (i == abort_at) begin
                check("abort_busy", busy, 1'b0);
                check("abort_crc_err", crc_err, 1'b0);
                gap(); gap(); gap();
                return;
            end
            if (i == len - 1) begin
                check("done_latency", crc_check_done, 1'b1);
                gap();
                check("done_pulse_end", crc_check_done, 1'b0);
                check("busy_after_check", busy, 1'b0);
            end else begin
                gap();
                if (fd && (i % 4 == 3)) begin
                    send_bit(~b, 1'b1, 1'b0, 1'b0, 1'b0, 0); gap();
                end
            end
        end
    endtask

    initial begin
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_sel", crc_sel, 2'd0);
        check("rst_done", crc_check_done, 1'b0);
        check("rst_crc_err", crc_err, 1'b0);
        check("rst_stuff_err", stuff_cnt_err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        gap();

        // Classic frame, correct CRC
        frame(1'b0, 4'd8, 2, 4'd0, 21'h4599, 15, 4'b0_0_00, -1);
        // Classic frame, corrupted LSB; error held until the next SOF
        frame(1'b0, 4'd8, 0, 4'd0, 21'h4598, 15, 4'b1_0_00, -1);
        gap(); gap(); gap();
        check("crc_err_held", crc_err, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        check("crc_err_cleared_sof", crc_err, 1'b0);
        check("busy_after_sof", busy, 1'b1);
        gap();
        // FD dlc=10, five stuff bits: good and bad stuff-count field
        frame(1'b1, 4'd10, 5, 4'b1111, 21'h1ABCD, 17, 4'b0_0_01, -1);
        frame(1'b1, 4'd10, 5, 4'b1110, 21'h1ABCD, 17, 4'b0_1_01, -1);
        // FD dlc=11, nine stuff bits wrap the counter to 1
        frame(1'b1, 4'd11, 9, 4'b0011, 21'h15A5A5, 21, 4'b0_0_10, -1);
        // Abort at the 8th CRC bit, then a clean frame
        frame(1'b0, 4'd3, 0, 4'd0, 21'h4599, 15, 4'b0_0_00, 7);
        check("abort_no_done", crc_check_done, 1'b0);
        frame(1'b0, 4'd3, 1, 4'd0, 21'h4599, 15, 4'b0_0_00, -1);

        // Asynchronous reset mid-SCNT with the clock stopped
        fdf = 1'b1; dlc = 4'd11;
        send_bit(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1); gap();
        send_bit(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);  gap();
        send_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);  gap();
        check("scnt_busy", busy, 1'b1);
        check("scnt_sel", crc_sel, 2'd2);
        clk_en = 1'b0;
        #20;
        rst = 1'b0;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_sel", crc_sel, 2'd0);
        check("async_rst_done", crc_check_done, 1'b0);
        #10;
        rst = 1'b1;
        clk_en = 1'b1;
        @(posedge clk); #1;
        // crc_field_start while IDLE is ignored
        send_bit(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0); gap();
        check("idle_cfs_busy", busy, 1'b0);
        check("idle_cfs_sel", crc_sel, 2'd0);

        gap(); gap();
        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
